// File: rtl/adc_clk_pkg.sv
// Shared definitions for the ADC clock monitor: state encoding and default
// qualification/dropout lengths.
package adc_clk_pkg;

    typedef enum logic [1:0] {
        ST_LOST    = 2'b00,
        ST_QUALIFY = 2'b01,
        ST_LOCKED  = 2'b10,
        ST_HOLDOFF = 2'b11
    } mon_state_e;

    localparam int unsigned DEF_QUAL_CYCLES    = 1024;
    localparam int unsigned DEF_DROPOUT_CYCLES = 8;

    function automatic logic is_locked_state(input mon_state_e s);
        return (s == ST_LOCKED) || (s == ST_HOLDOFF);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; an increment coincident
// with a clear restarts the count at one so the event is not lost.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i && inc_i) begin
            count_d = W'(1);
        end else if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/adc_clock_monitor.sv
// Qualifies the raw ADC clock-valid flag into a lock indication, holds the ADC
// capture path in reset while unlocked, and records loss events.
//
//   state   | meaning
//   LOST    | no qualified clock; ADC path held in reset
//   QUALIFY | counting consecutive valid samples toward lock
//   LOCKED  | qualified clock present
//   HOLDOFF | locked, riding through a short run of invalid samples
module adc_clock_monitor
    import adc_clk_pkg::*;
#(
    parameter int unsigned QUAL_CYCLES    = DEF_QUAL_CYCLES,
    parameter int unsigned DROPOUT_CYCLES = DEF_DROPOUT_CYCLES,
    parameter int unsigned LOSS_CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_valid_in,
    input  logic                  clear_sticky,
    output logic                  adc_clk_locked,
    output logic                  adc_path_reset,
    output logic                  clk_lost_sticky,
    output logic [LOSS_CNT_W-1:0] loss_count,
    output logic [1:0]            mon_state
);

    localparam int unsigned QW = $clog2(QUAL_CYCLES);
    localparam int unsigned DW = $clog2(DROPOUT_CYCLES + 1);
    localparam logic [QW-1:0] QUAL_LAST = QW'(QUAL_CYCLES - 1);
    localparam logic [DW-1:0] DROP_LAST = DW'(DROPOUT_CYCLES - 1);

    mon_state_e    state_q, state_d;
    logic [QW-1:0] qual_cnt_q, qual_cnt_d;
    logic [DW-1:0] drop_cnt_q, drop_cnt_d;
    logic          valid_q;
    logic          locked_q, path_reset_q, sticky_q;
    logic          loss_evt;

    // The valid flag is registered once before the FSM; this sample stage is
    // what puts lock at QUAL_CYCLES+1 cycles after the flag first goes high.
    always_comb begin
        state_d    = state_q;
        qual_cnt_d = qual_cnt_q;
        drop_cnt_d = drop_cnt_q;
        loss_evt   = 1'b0;
        case (state_q)
            ST_LOST: begin
                if (valid_q) begin
                    state_d    = ST_QUALIFY;
                    qual_cnt_d = QW'(1);
                end else begin
                    qual_cnt_d = '0;
                end
            end
            ST_QUALIFY: begin
                if (!valid_q) begin
                    state_d    = ST_LOST;
                    qual_cnt_d = '0;
                end else if (qual_cnt_q == QUAL_LAST) begin
                    state_d    = ST_LOCKED;
                    qual_cnt_d = '0;
                end else begin
                    qual_cnt_d = qual_cnt_q + QW'(1);
                end
            end
            ST_LOCKED: begin
                if (!valid_q) begin
                    if (DROPOUT_CYCLES == 1) begin
                        state_d  = ST_LOST;
                        loss_evt = 1'b1;
                    end else begin
                        state_d    = ST_HOLDOFF;
                        drop_cnt_d = DW'(1);
                    end
                end
            end
            ST_HOLDOFF: begin
                if (valid_q) begin
                    state_d    = ST_LOCKED;
                    drop_cnt_d = '0;
                end else if (drop_cnt_q == DROP_LAST) begin
                    state_d    = ST_LOST;
                    drop_cnt_d = '0;
                    loss_evt   = 1'b1;
                end else begin
                    drop_cnt_d = drop_cnt_q + DW'(1);
                end
            end
            default: begin
                state_d    = ST_LOST;
                qual_cnt_d = '0;
                drop_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            state_q      <= ST_LOST;
            qual_cnt_q   <= '0;
            drop_cnt_q   <= '0;
            locked_q     <= 1'b0;
            path_reset_q <= 1'b1;
            sticky_q     <= 1'b0;
        end else begin
            valid_q      <= clk_valid_in;
            state_q      <= state_d;
            qual_cnt_q   <= qual_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            locked_q     <= is_locked_state(state_d);
            path_reset_q <= !is_locked_state(state_d);
            if (loss_evt) begin
                sticky_q <= 1'b1;
            end else if (clear_sticky) begin
                sticky_q <= 1'b0;
            end
        end
    end

    sat_counter #(
        .W (LOSS_CNT_W)
    ) u_loss_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (loss_evt),
        .clr_i   (clear_sticky),
        .count_o (loss_count)
    );

    assign adc_clk_locked  = locked_q;
    assign adc_path_reset  = path_reset_q;
    assign clk_lost_sticky = sticky_q;
    assign mon_state       = state_q;

endmodule

// File: tb/tb_adc_clock_monitor.sv
// Directed bench for adc_clock_monitor: one instance at 16/4/4 and a second at
// the minimum qualification length with single-cycle dropout tolerance.
module tb_adc_clock_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       valid = 1'b0;
    logic       clear = 1'b0;
    logic       valid1 = 1'b0;
    logic       clear1 = 1'b0;

    logic       locked, prst, sticky;
    logic [3:0] lcnt;
    logic [1:0] mon;
    logic       locked1, prst1, sticky1;
    logic [1:0] lcnt1;
    logic [1:0] mon1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adc_clock_monitor #(
        .QUAL_CYCLES    (16),
        .DROPOUT_CYCLES (4),
        .LOSS_CNT_W     (4)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clk_valid_in    (valid),
        .clear_sticky    (clear),
        .adc_clk_locked  (locked),
        .adc_path_reset  (prst),
        .clk_lost_sticky (sticky),
        .loss_count      (lcnt),
        .mon_state       (mon)
    );

    adc_clock_monitor #(
        .QUAL_CYCLES    (2),
        .DROPOUT_CYCLES (1),
        .LOSS_CNT_W     (2)
    ) u_dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .clk_valid_in    (valid1),
        .clear_sticky    (clear1),
        .adc_clk_locked  (locked1),
        .adc_path_reset  (prst1),
        .clk_lost_sticky (sticky1),
        .loss_count      (lcnt1),
        .mon_state       (mon1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v);
        valid = v;
        @(posedge clk);
        #1;
    endtask

    // From LOST with the sampled flag low: lock appears on the 17th edge.
    task automatic relock();
        for (int i = 1; i <= 17; i++) begin
            step(1'b1);
            if (i == 16) check("relock_pre", {31'd0, locked}, 32'd0);
        end
        check("relock", {31'd0, locked}, 32'd1);
    endtask

    // From LOCKED with the sampled flag high: loss lands on the 5th edge.
    task automatic lose();
        repeat (4) step(1'b0);
        check("lose_holdoff", {30'd0, mon}, 32'd3);
        step(1'b0);
        check("lose_lost", {30'd0, mon}, 32'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_prst", {31'd0, prst}, 32'd1);
        check("rst_sticky", {31'd0, sticky}, 32'd0);
        check("rst_lcnt", {28'd0, lcnt}, 32'd0);
        check("rst_mon", {30'd0, mon}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // single-cycle dropout tolerance: LOCKED goes straight to LOST
        valid1 = 1'b1;
        step(1'b0);
        step(1'b0);
        check("d1_qualify", {30'd0, mon1}, 32'd1);
        step(1'b0);
        check("d1_locked", {31'd0, locked1}, 32'd1);
        check("d1_mon_locked", {30'd0, mon1}, 32'd2);
        valid1 = 1'b0;
        step(1'b0);
        check("d1_still_locked", {30'd0, mon1}, 32'd2);
        step(1'b0);
        check("d1_mon_lost", {30'd0, mon1}, 32'd0);
        check("d1_prst", {31'd0, prst1}, 32'd1);
        check("d1_sticky", {31'd0, sticky1}, 32'd1);
        check("d1_lcnt", {30'd0, lcnt1}, 32'd1);

        // continuous valid after reset
        for (int i = 1; i <= 17; i++) begin
            step(1'b1);
            if (i == 2) check("lock_qualify", {30'd0, mon}, 32'd1);
            if (i == 16) begin
                check("lock_pre_locked", {31'd0, locked}, 32'd0);
                check("lock_pre_prst", {31'd0, prst}, 32'd1);
            end
        end
        check("lock_locked", {31'd0, locked}, 32'd1);
        check("lock_prst", {31'd0, prst}, 32'd0);
        check("lock_mon", {30'd0, mon}, 32'd2);

        // three-cycle dropout is ridden through
        step(1'b0);
        check("ride_mon0", {30'd0, mon}, 32'd2);
        step(1'b0);
        check("ride_mon1", {30'd0, mon}, 32'd3);
        check("ride_locked1", {31'd0, locked}, 32'd1);
        step(1'b0);
        check("ride_mon2", {30'd0, mon}, 32'd3);
        step(1'b1);
        check("ride_mon3", {30'd0, mon}, 32'd3);
        check("ride_locked3", {31'd0, locked}, 32'd1);
        step(1'b1);
        check("ride_mon4", {30'd0, mon}, 32'd2);
        check("ride_lcnt", {28'd0, lcnt}, 32'd0);
        check("ride_sticky", {31'd0, sticky}, 32'd0);

        // four-cycle dropout is a loss
        lose();
        check("loss_locked", {31'd0, locked}, 32'd0);
        check("loss_prst", {31'd0, prst}, 32'd1);
        check("loss_sticky", {31'd0, sticky}, 32'd1);
        check("loss_lcnt", {28'd0, lcnt}, 32'd1);

        clear = 1'b1;
        step(1'b0);
        clear = 1'b0;
        check("clr_sticky", {31'd0, sticky}, 32'd0);
        check("clr_lcnt", {28'd0, lcnt}, 32'd0);
        check("clr_mon", {30'd0, mon}, 32'd0);

        // interrupted qualification restarts from one
        for (int i = 1; i <= 10; i++) begin
            step(1'b1);
            if (i == 2) check("iq_qualify", {30'd0, mon}, 32'd1);
        end
        step(1'b0);
        check("iq_cyc11_mon", {30'd0, mon}, 32'd1);
        check("iq_cyc11_locked", {31'd0, locked}, 32'd0);
        step(1'b1);
        check("iq_lost", {30'd0, mon}, 32'd0);
        step(1'b1);
        check("iq_requal", {30'd0, mon}, 32'd1);
        for (int i = 14; i <= 27; i++) step(1'b1);
        check("iq_pre_lock", {31'd0, locked}, 32'd0);
        check("iq_pre_mon", {30'd0, mon}, 32'd1);
        step(1'b1);
        check("iq_lock", {31'd0, locked}, 32'd1);
        check("iq_lock_mon", {30'd0, mon}, 32'd2);

        // loss counter saturation
        for (int n = 1; n <= 20; n++) begin
            lose();
            check("sat_lcnt", {28'd0, lcnt}, (n > 15) ? 32'd15 : 32'(n));
            relock();
        end
        check("sat_sticky", {31'd0, sticky}, 32'd1);

        repeat (4) step(1'b0);
        clear = 1'b1;
        step(1'b0);
        clear = 1'b0;
        check("coinc_lcnt", {28'd0, lcnt}, 32'd1);
        check("coinc_sticky", {31'd0, sticky}, 32'd1);
        check("coinc_mon", {30'd0, mon}, 32'd0);
        step(1'b0);
        check("coinc_hold_lcnt", {28'd0, lcnt}, 32'd1);

        // asynchronous reset while locked
        relock();
        #2 rst_n = 1'b0;
        #1;
        check("arst_locked", {31'd0, locked}, 32'd0);
        check("arst_prst", {31'd0, prst}, 32'd1);
        check("arst_sticky", {31'd0, sticky}, 32'd0);
        check("arst_lcnt", {28'd0, lcnt}, 32'd0);
        check("arst_mon", {30'd0, mon}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1);
        check("post_rst_mon0", {30'd0, mon}, 32'd0);
        step(1'b1);
        check("post_rst_mon1", {30'd0, mon}, 32'd1);
        check("post_rst_locked", {31'd0, locked}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_clock_monitor.md
ADC_CLOCK_MONITOR -- requirements
Module: adc_clock_monitor

Interface
REQ-001 Parameter: QUAL_CYCLES, default 1024, consecutive valid samples required to declare lock (range 2..65535).
REQ-002 Parameter: DROPOUT_CYCLES, default 8, consecutive invalid samples tolerated while locked before loss (range 1..255).
REQ-003 Parameter: LOSS_CNT_W, default 8, width of loss event counter.
REQ-004 Port list:
- clk  input  1  system clock, same domain as the fast-clock-input block's sys_clk.
- rst_n  input  1  reset.
- clk_valid_in  input  1  raw ADC clock valid flag, already in clk domain.
- clear_sticky  input  1  single-cycle pulse; clears clk_lost_sticky and loss_count.
- adc_clk_locked  output  1  qualified ADC clock present.
- adc_path_reset  output  1  active-high hold-reset for ADC capture logic.
- clk_lost_sticky  output  1  set on any loss event.
- loss_count  output  LOSS_CNT_W  saturating loss event count.
- mon_state  output  2  current FSM state, for debug.
REQ-005 One clock; reset is asynchronous and active-low.

Function
REQ-006 FSM states, encoding: LOST=2'b00, QUALIFY=2'b01, LOCKED=2'b10, HOLDOFF=2'b11; all outputs registered.
REQ-007 LOST: clk_valid_in=1 -> QUALIFY, qual_cnt<=1; else stay, qual_cnt<=0.
REQ-008 QUALIFY: clk_valid_in=0 -> LOST, qual_cnt<=0; clk_valid_in=1 and qual_cnt==QUAL_CYCLES-1 -> LOCKED; else qual_cnt+1.
REQ-009 Lock latency: adc_clk_locked rises exactly QUAL_CYCLES+1 cycles after the first of QUAL_CYCLES consecutive valid samples.
REQ-010 LOCKED: clk_valid_in=0 -> HOLDOFF, drop_cnt<=1; else stay.
REQ-011 HOLDOFF: clk_valid_in=1 -> LOCKED, drop_cnt<=0; clk_valid_in=0 and drop_cnt==DROPOUT_CYCLES-1 -> LOST (loss event); else drop_cnt+1.
REQ-012 DROPOUT_CYCLES=1: first invalid sample in LOCKED -> LOST directly (HOLDOFF unused).
REQ-013 adc_clk_locked=1 in LOCKED and HOLDOFF; 0 in LOST and QUALIFY.
REQ-014 adc_path_reset = not adc_clk_locked, same cycle; never both 0 or both 1.
REQ-015 Loss event: clk_lost_sticky<=1; loss_count increments, saturates at all-ones, no wrap.
REQ-016 clear_sticky alone: clk_lost_sticky<=0, loss_count<=0 next cycle; FSM unaffected.
REQ-017 clear_sticky coincident with loss event: loss wins; clk_lost_sticky=1, loss_count=1.
REQ-018 qual_cnt width = clog2(QUAL_CYCLES); drop_cnt width = clog2(DROPOUT_CYCLES+1); no counter overflow possible.
REQ-019 Unknown/unused state encodings: none exist (2-bit full coverage); default branch -> LOST.

Reset
REQ-020 rst_n low: state=LOST, qual_cnt=0, drop_cnt=0, adc_clk_locked=0, adc_path_reset=1, clk_lost_sticky=0, loss_count=0, mon_state=2'b00, asynchronously.
REQ-021 Reset mid-lock is not a loss event; sticky and counter cleared, requalification required.
REQ-022 rst_n deassertion: synchronous to clk upstream; first FSM evaluation on first clk edge after release.

Structure
REQ-023 Shared package adc_clk_pkg: state typedef/encoding constants, default QUAL_CYCLES/DROPOUT_CYCLES.
REQ-024 One sub-module: sat_counter (parameterised width, inc, clr, saturating, clr-vs-inc priority to inc-from-zero) for loss_count.
REQ-025 Implementation 120-400 lines RTL; no clock gating, no multicycle paths.

Verification (QUAL_CYCLES=16, DROPOUT_CYCLES=4, LOSS_CNT_W=4)
REQ-026 Reset release, clk_valid_in=1 continuous -> adc_clk_locked rises at cycle 17 after first valid, adc_path_reset falls same cycle.
REQ-027 Valid 10 cycles, 1 cycle invalid, valid 16 -> no lock at cycle 11; lock 17 cycles after restart; mon_state 01->00->01->10.
REQ-028 Locked, invalid 3 cycles then valid -> adc_clk_locked stays 1, mon_state 11 for 3 cycles, loss_count=0.
REQ-029 Locked, invalid 4 cycles -> LOST on 4th sample edge, adc_clk_locked=0, sticky=1, loss_count=1.
REQ-030 Force 20 loss events -> loss_count saturates at 15; clear_sticky coincident with 21st loss -> loss_count=1, sticky=1.
REQ-031 rst_n asserted while LOCKED -> all outputs to reset values without clk edge; loss_count=0, sticky=0.
